site_registry: RTL and testbench

- Stores nest and sugar-patch centre coordinates during simulation setup and answers placement collision queries.
- Sits beside the setup sequencer. It consumes the sequencer's nest/patch write strobes and candidate coordinates, and returns `collision` in the same cycle.
- Publishes the packed `nests_X`/`nests_Y` and `patches_X`/`patches_Y` arrays to the ant seeding logic, the sugar-placement logic and the run-time ant logic.
- Valid masks and full flags let downstream logic ignore unplaced or depleted sites.

---
 rtl/site_registry_pkg.sv | 20 ++
 rtl/site_registry_site_overlap.sv | 24 ++
 rtl/site_registry.sv | 115 +++++++++++
 tb/tb_site_registry.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/site_registry_pkg.sv
// Shared geometry and sizing parameters for the nest / sugar-patch site registry.
package site_registry_pkg;
  localparam int PIXELS_X          = 256;
  localparam int PIXELS_Y          = 128;
  localparam int X_bits            = 8;
  localparam int Y_bits            = 7;
  localparam int NEST_num          = 4;
  localparam int SUGARPATCH_num    = 8;
  localparam int NEST_RADIUS       = 4;
  localparam int SUGARPATCH_RADIUS = 3;
  localparam int SITE_GAP          = 2;

  // Slot-index width; at least one bit so a single-slot table still has a port.
  function automatic int id_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NEST_num_bits       = id_bits(NEST_num);
  localparam int SUGARPATCH_num_bits = id_bits(SUGARPATCH_num);
endpackage

// File: rtl/site_registry_site_overlap.sv
// Single-site box test: both absolute centre distances within the combined half-extent.
module site_overlap #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          valid_i,
  input  logic [XW-1:0] qx_i,
  input  logic [YW-1:0] qy_i,
  input  logic [XW-1:0] sx_i,
  input  logic [YW-1:0] sy_i,
  input  logic [XW:0]   thr_x_i,
  input  logic [YW:0]   thr_y_i,
  output logic          hit_o
);
  logic [XW:0] dx;
  logic [YW:0] dy;

  // One extra bit keeps edge-to-edge distances from wrapping into false hits.
  always_comb begin
    dx = (qx_i >= sx_i) ? ({1'b0, qx_i} - {1'b0, sx_i}) : ({1'b0, sx_i} - {1'b0, qx_i});
    dy = (qy_i >= sy_i) ? ({1'b0, qy_i} - {1'b0, sy_i}) : ({1'b0, sy_i} - {1'b0, qy_i});
    hit_o = valid_i && (dx <= thr_x_i) && (dy <= thr_y_i);
  end
endmodule

// File: rtl/site_registry.sv
// Nest / sugar-patch site table with same-cycle placement collision query.
module site_registry
  import site_registry_pkg::*;
#(
  parameter int N_NEST  = NEST_num,
  parameter int N_PATCH = SUGARPATCH_num,
  parameter int NB      = id_bits(N_NEST),
  parameter int PB      = id_bits(N_PATCH)
) (
  input  logic                           setup_clk,
  input  logic                           RESET_SIM,
  input  logic                           nest_wr,
  input  logic [NB-1:0]                  nest_id,
  input  logic [X_bits-1:0]              nest_x,
  input  logic [Y_bits-1:0]              nest_y,
  input  logic                           patch_wr,
  input  logic                           patch_clear,
  input  logic [PB-1:0]                  patch_id,
  input  logic [X_bits-1:0]              patch_x,
  input  logic [Y_bits-1:0]              patch_y,
  input  logic                           query_is_patch,
  input  logic [X_bits-1:0]              collide_x,
  input  logic [Y_bits-1:0]              collide_y,
  output logic                           collision,
  output logic [N_NEST-1:0][X_bits-1:0]  nests_X,
  output logic [N_NEST-1:0][Y_bits-1:0]  nests_Y,
  output logic [N_PATCH-1:0][X_bits-1:0] patches_X,
  output logic [N_PATCH-1:0][Y_bits-1:0] patches_Y,
  output logic [N_NEST-1:0]              nest_valid,
  output logic [N_PATCH-1:0]             patch_valid,
  output logic                           nests_full,
  output logic                           patches_full
);
  logic [N_NEST-1:0][X_bits-1:0]  nx_q, nx_d;
  logic [N_NEST-1:0][Y_bits-1:0]  ny_q, ny_d;
  logic [N_PATCH-1:0][X_bits-1:0] px_q, px_d;
  logic [N_PATCH-1:0][Y_bits-1:0] py_q, py_d;
  logic [N_NEST-1:0]              nv_q, nv_d;
  logic [N_PATCH-1:0]             pv_q, pv_d;

  // Slot matching by equality means ids beyond the table simply select nothing.
  always_comb begin
    nx_d = nx_q; ny_d = ny_q; nv_d = nv_q;
    px_d = px_q; py_d = py_q; pv_d = pv_q;
    for (int i = 0; i < N_NEST; i++) begin
      if (nest_wr && nest_id == NB'(i)) begin
        nx_d[i] = nest_x;
        ny_d[i] = nest_y;
        nv_d[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_PATCH; i++) begin
      if (patch_wr && patch_id == PB'(i)) begin
        px_d[i] = patch_x;
        py_d[i] = patch_y;
        pv_d[i] = 1'b1;
      end else if (patch_clear && patch_id == PB'(i)) begin
        pv_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge setup_clk or posedge RESET_SIM) begin
    if (RESET_SIM) begin
      nx_q <= '0; ny_q <= '0; nv_q <= '0;
      px_q <= '0; py_q <= '0; pv_q <= '0;
    end else begin
      nx_q <= nx_d; ny_q <= ny_d; nv_q <= nv_d;
      px_q <= px_d; py_q <= py_d; pv_q <= pv_d;
    end
  end

  localparam int T_NN = 2 * NEST_RADIUS + SITE_GAP;
  localparam int T_NP = NEST_RADIUS + SUGARPATCH_RADIUS + SITE_GAP;
  localparam int T_PP = 2 * SUGARPATCH_RADIUS + SITE_GAP;

  logic [X_bits:0] thr_nx, thr_px;
  logic [Y_bits:0] thr_ny, thr_py;

  always_comb begin
    thr_nx = query_is_patch ? (X_bits+1)'(T_NP) : (X_bits+1)'(T_NN);
    thr_ny = query_is_patch ? (Y_bits+1)'(T_NP) : (Y_bits+1)'(T_NN);
    thr_px = query_is_patch ? (X_bits+1)'(T_PP) : (X_bits+1)'(T_NP);
    thr_py = query_is_patch ? (Y_bits+1)'(T_PP) : (Y_bits+1)'(T_NP);
  end

  logic [N_NEST-1:0]  nest_hit;
  logic [N_PATCH-1:0] patch_hit;

  for (genvar i = 0; i < N_NEST; i++) begin : g_nest
    site_overlap #(.XW(X_bits), .YW(Y_bits)) u_ovl (
      .valid_i(nv_q[i]), .qx_i(collide_x), .qy_i(collide_y),
      .sx_i(nx_q[i]), .sy_i(ny_q[i]),
      .thr_x_i(thr_nx), .thr_y_i(thr_ny), .hit_o(nest_hit[i])
    );
  end

  for (genvar i = 0; i < N_PATCH; i++) begin : g_patch
    site_overlap #(.XW(X_bits), .YW(Y_bits)) u_ovl (
      .valid_i(pv_q[i]), .qx_i(collide_x), .qy_i(collide_y),
      .sx_i(px_q[i]), .sy_i(py_q[i]),
      .thr_x_i(thr_px), .thr_y_i(thr_py), .hit_o(patch_hit[i])
    );
  end

  assign collision    = |nest_hit || |patch_hit;
  assign nests_X      = nx_q;
  assign nests_Y      = ny_q;
  assign patches_X    = px_q;
  assign patches_Y    = py_q;
  assign nest_valid   = nv_q;
  assign patch_valid  = pv_q;
  assign nests_full   = &nv_q;
  assign patches_full = &pv_q;
endmodule

// File: tb/tb_site_registry.sv
// Directed checks for site_registry with a 3-slot nest table and 8 patch slots.
module tb_site_registry;
  logic       setup_clk = 1'b0;
  logic       RESET_SIM;
  logic       nest_wr;
  logic [1:0] nest_id;
  logic [7:0] nest_x;
  logic [6:0] nest_y;
  logic       patch_wr, patch_clear;
  logic [2:0] patch_id;
  logic [7:0] patch_x;
  logic [6:0] patch_y;
  logic       query_is_patch;
  logic [7:0] collide_x;
  logic [6:0] collide_y;
  logic       collision;
  logic [2:0][7:0] nests_X;
  logic [2:0][6:0] nests_Y;
  logic [7:0][7:0] patches_X;
  logic [7:0][6:0] patches_Y;
  logic [2:0] nest_valid;
  logic [7:0] patch_valid;
  logic       nests_full, patches_full;

  int n_chk  = 0;
  int n_pass = 0;

  site_registry #(.N_NEST(3), .N_PATCH(8)) dut (
    .setup_clk(setup_clk), .RESET_SIM(RESET_SIM),
    .nest_wr(nest_wr), .nest_id(nest_id), .nest_x(nest_x), .nest_y(nest_y),
    .patch_wr(patch_wr), .patch_clear(patch_clear), .patch_id(patch_id),
    .patch_x(patch_x), .patch_y(patch_y),
    .query_is_patch(query_is_patch), .collide_x(collide_x), .collide_y(collide_y),
    .collision(collision),
    .nests_X(nests_X), .nests_Y(nests_Y), .patches_X(patches_X), .patches_Y(patches_Y),
    .nest_valid(nest_valid), .patch_valid(patch_valid),
    .nests_full(nests_full), .patches_full(patches_full)
  );

  always #5 setup_clk = ~setup_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge setup_clk);
    #1;
    nest_wr = 0; patch_wr = 0; patch_clear = 0;
  endtask

  task automatic wr_nest(input logic [1:0] id, input logic [7:0] x, input logic [6:0] y);
    nest_wr = 1; nest_id = id; nest_x = x; nest_y = y;
    tick();
  endtask

  task automatic wr_patch(input logic [2:0] id, input logic [7:0] x, input logic [6:0] y, input logic clr);
    patch_wr = 1; patch_clear = clr; patch_id = id; patch_x = x; patch_y = y;
    tick();
  endtask

  task automatic query(input string tag, input logic is_p, input logic [7:0] x,
                       input logic [6:0] y, input logic exp);
    query_is_patch = is_p; collide_x = x; collide_y = y;
    #1;
    chk(tag, collision, exp);
  endtask

  task automatic do_reset();
    #2 RESET_SIM = 1;
    #1;
    chk("rst_nest_valid", nest_valid, 0);
    chk("rst_patch_valid", patch_valid, 0);
    chk("rst_nests_X", nests_X, 0);
    #3 RESET_SIM = 0;
    tick();
  endtask

  initial begin
    RESET_SIM = 1; nest_wr = 0; patch_wr = 0; patch_clear = 0;
    nest_id = 0; nest_x = 0; nest_y = 0; patch_id = 0; patch_x = 0; patch_y = 0;
    query_is_patch = 0; collide_x = 0; collide_y = 0;
    #12 RESET_SIM = 0;
    tick();
    chk("init_collision", collision, 0);
    chk("init_nests_full", nests_full, 0);
    chk("init_patches_full", patches_full, 0);

    // Out-of-range id on a 3-slot table, then fill it.
    wr_nest(2'd3, 8'd9, 7'd9);
    chk("oor_nest_valid", nest_valid, 3'b000);
    chk("oor_nests_X", nests_X, 0);
    wr_nest(0, 8'd10, 7'd20);
    wr_nest(1, 8'd50, 7'd40);
    chk("partial_full", nests_full, 0);
    wr_nest(2, 8'd120, 7'd100);
    chk("nest_valid_3", nest_valid, 3'b111);
    chk("nests_full", nests_full, 1);
    chk("nests_X_2", nests_X[2], 120);

    // Mid-run reset drops every site at once.
    do_reset();
    query("rst_query", 0, 8'd50, 7'd40, 0);

    wr_nest(0, 8'd80, 7'd60);
    chk("n0_x", nests_X[0], 80);
    chk("n0_y", nests_Y[0], 60);
    chk("n0_valid", nest_valid, 3'b001);
    query("nn_dx10", 0, 8'd90, 7'd60, 1);
    query("nn_dx11", 0, 8'd91, 7'd60, 0);
    query("nn_dxneg10", 0, 8'd70, 7'd60, 1);
    query("nn_dy10", 0, 8'd80, 7'd70, 1);
    query("nn_dy11", 0, 8'd80, 7'd71, 0);
    query("np_dx9", 1, 8'd89, 7'd60, 1);
    query("np_dx10", 1, 8'd90, 7'd60, 0);

    // Combined write+clear: the write wins.
    wr_patch(3'd2, 8'd30, 7'd30, 1);
    chk("wc_valid", patch_valid, 8'b0000_0100);
    chk("wc_x", patches_X[2], 30);
    query("pp_hit", 1, 8'd38, 7'd30, 1);
    query("pp_miss", 1, 8'd39, 7'd30, 0);
    query("pn_hit", 0, 8'd39, 7'd30, 1);
    patch_clear = 1; patch_id = 3'd2;
    tick();
    chk("clr_valid", patch_valid, 0);
    chk("clr_keep_x", patches_X[2], 30);
    query("clr_query", 0, 8'd30, 7'd30, 0);

    // A write does not affect the collision result in its own cycle.
    @(negedge setup_clk);
    nest_wr = 1; nest_id = 2'd1; nest_x = 8'd200; nest_y = 7'd100;
    patch_wr = 1; patch_id = 3'd5; patch_x = 8'd10; patch_y = 7'd10;
    query("same_cycle", 0, 8'd200, 7'd100, 0);
    tick();
    query("after_write", 0, 8'd200, 7'd100, 1);
    chk("both_nest_valid", nest_valid, 3'b011);
    chk("both_patch_valid", patch_valid, 8'b0010_0000);
    chk("both_patch_y", patches_Y[5], 10);

    for (int i = 0; i < 8; i++) wr_patch(3'(i), 8'(i * 20), 7'd5, 0);
    chk("patches_full", patches_full, 1);
    chk("patch_x7", patches_X[7], 140);

    // Corner cases: no wrap-around between opposite corners.
    do_reset();
    wr_nest(0, 8'd0, 7'd0);
    query("corner_far", 0, 8'd255, 7'd127, 0);
    wr_nest(0, 8'd255, 7'd127);
    query("corner_near", 0, 8'd247, 7'd119, 1);
    query("corner_miss", 0, 8'd244, 7'd127, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
